framebuffer_writer: RTL



---
 rtl/vga_pkg.sv | 44 ++++
 rtl/fb_clip.sv | 45 ++++
 rtl/framebuffer_writer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA frame memory write path.
//   SCREEN_X / SCREEN_Y : visible resolution in pixels
//   COLOR_BITS          : bits per stored pixel (bit0 red, bit1 green, bit2 blue)
//   FB_ADDR_BITS        : frame memory address width
//   fb_cmd_t            : one draw command (pixel or rectangle fill)
//   fb_state_t          : write engine FSM encoding
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int SCREEN_X     = 320;
   localparam int SCREEN_Y     = 240;
   localparam int COLOR_BITS   = 3;
   localparam int FB_ADDR_BITS = 17;
   localparam int COORD_BITS   = 10;
   // One bit wider than a coordinate so x+w style arithmetic cannot wrap.
   localparam int CLIP_BITS    = COORD_BITS + 1;

   typedef logic [FB_ADDR_BITS-1:0] fb_addr_t;
   typedef logic [COORD_BITS-1:0]   fb_coord_t;
   typedef logic [COLOR_BITS-1:0]   fb_color_t;

   typedef struct packed {
      logic      fill;
      fb_coord_t x;
      fb_coord_t y;
      fb_coord_t w;
      fb_coord_t h;
      fb_color_t color;
   } fb_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } fb_state_t;

   // Address of column 0 of row y. Only evaluated once per command.
   function automatic fb_addr_t row_base(input logic [COORD_BITS-1:0] y);
      return fb_addr_t'(y) * fb_addr_t'(SCREEN_X);
   endfunction

endpackage

// File: rtl/fb_clip.sv
// ---------------------------------------------------------------------------
// fb_clip
// Combinational clip of a rectangle against the visible screen.
//   x, y : start column / row
//   w, h : requested width / height
//   ew   : min(w, SCREEN_X-x) when x < SCREEN_X, else 0
//   eh   : min(h, SCREEN_Y-y) when y < SCREEN_Y, else 0
// All arithmetic is CLIP_BITS wide so the room subtraction never wraps.
// ---------------------------------------------------------------------------
module fb_clip
   import vga_pkg::*;
(
   input  logic [COORD_BITS-1:0] x,
   input  logic [COORD_BITS-1:0] y,
   input  logic [COORD_BITS-1:0] w,
   input  logic [COORD_BITS-1:0] h,
   output logic [CLIP_BITS-1:0]  ew,
   output logic [CLIP_BITS-1:0]  eh
);

   logic [CLIP_BITS-1:0] x_w;
   logic [CLIP_BITS-1:0] y_w;
   logic [CLIP_BITS-1:0] w_w;
   logic [CLIP_BITS-1:0] h_w;
   logic [CLIP_BITS-1:0] x_room;
   logic [CLIP_BITS-1:0] y_room;

   always_comb begin
      x_w    = {1'b0, x};
      y_w    = {1'b0, y};
      w_w    = {1'b0, w};
      h_w    = {1'b0, h};
      x_room = CLIP_BITS'(SCREEN_X) - x_w;
      y_room = CLIP_BITS'(SCREEN_Y) - y_w;
      ew     = '0;
      eh     = '0;
      if (x_w < CLIP_BITS'(SCREEN_X)) begin
         ew = (w_w < x_room) ? w_w : x_room;
      end
      if (y_w < CLIP_BITS'(SCREEN_Y)) begin
         eh = (h_w < y_room) ? h_w : y_room;
      end
   end

endmodule

// File: rtl/framebuffer_writer.sv
// ---------------------------------------------------------------------------
// framebuffer_writer
// Write-side engine for the VGA frame memory. Accepts pixel / rectangle-fill
// commands and issues one clipped memory write per cycle in raster order.
// Colours are stored inverted (stored 0 = channel at full intensity).
//
// Ports
//   clock, reset          : rising-edge clock, async active-high reset
//   cmd_valid / cmd_ready : command handshake
//   cmd_fill,x,y,w,h,color: command fields (w/h used only for fills)
//   mem_we/addr/data      : registered frame memory write port
//   busy                  : command in progress (WRITE or DONE)
//   done                  : one-cycle pulse when a command completes
//   dbg_state             : current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1; cmd_ready is 1 exactly in IDLE and does not depend
// on cmd_valid. Inputs are ignored at all other times.
//
// Configuration macro FB_FILL_EN:
//   defined   : rectangle fills supported (row/column counters present)
//   undefined : every command is a single pixel; WRITE lasts one cycle
// ---------------------------------------------------------------------------
module framebuffer_writer
   import vga_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_fill,
   input  logic [COORD_BITS-1:0]   cmd_x,
   input  logic [COORD_BITS-1:0]   cmd_y,
   input  logic [COORD_BITS-1:0]   cmd_w,
   input  logic [COORD_BITS-1:0]   cmd_h,
   input  logic [COLOR_BITS-1:0]   cmd_color,
   output logic                    mem_we,
   output logic [FB_ADDR_BITS-1:0] mem_addr,
   output logic [COLOR_BITS-1:0]   mem_data,
   output logic                    busy,
   output logic                    done,
   output fb_state_t               dbg_state
);

   fb_cmd_t              cmd_in;
   logic [COORD_BITS-1:0] clip_w;
   logic [COORD_BITS-1:0] clip_h;
   logic [CLIP_BITS-1:0]  clip_ew;
   logic [CLIP_BITS-1:0]  clip_eh;
   logic                  clip_nonzero;

   fb_state_t state_q, state_d;
   logic      mem_we_q, mem_we_d;
   fb_addr_t  mem_addr_q, mem_addr_d;
   fb_color_t mem_data_q, mem_data_d;

`ifdef FB_FILL_EN
   logic [CLIP_BITS-1:0] col_q, col_d;
   logic [CLIP_BITS-1:0] row_q, row_d;
   logic [CLIP_BITS-1:0] ew_q, ew_d;
   logic [CLIP_BITS-1:0] eh_q, eh_d;
   // Address of the first pixel of the current row (row base + start x).
   fb_addr_t             row_start_q, row_start_d;
`endif

   assign cmd_in = '{fill: cmd_fill, x: cmd_x, y: cmd_y, w: cmd_w,
                     h: cmd_h, color: cmd_color};

`ifdef FB_FILL_EN
   // A single pixel is a 1x1 rectangle.
   assign clip_w = cmd_in.fill ? cmd_in.w : COORD_BITS'(1);
   assign clip_h = cmd_in.fill ? cmd_in.h : COORD_BITS'(1);
`else
   assign clip_w = COORD_BITS'(1);
   assign clip_h = COORD_BITS'(1);
   logic unused_fill_fields;
   assign unused_fill_fields = ^{cmd_in.fill, cmd_in.w, cmd_in.h};
`endif

   fb_clip u_clip (
      .x  (cmd_in.x),
      .y  (cmd_in.y),
      .w  (clip_w),
      .h  (clip_h),
      .ew (clip_ew),
      .eh (clip_eh)
   );

   assign clip_nonzero = (clip_ew != '0) && (clip_eh != '0);

   // ------------------------------------------------------------------
   // Next-state / output logic. The write registers always hold the write
   // being presented this cycle, so the accepting edge already loads the
   // first write.
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
`ifdef FB_FILL_EN
      col_d       = col_q;
      row_d       = row_q;
      ew_d        = ew_q;
      eh_d        = eh_q;
      row_start_d = row_start_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               mem_data_d = ~cmd_in.color;
`ifdef FB_FILL_EN
               col_d       = '0;
               row_d       = '0;
               ew_d        = clip_ew;
               eh_d        = clip_eh;
               row_start_d = row_base(cmd_in.y) + fb_addr_t'(cmd_in.x);
`endif
               if (clip_nonzero) begin
                  state_d    = ST_WRITE;
                  mem_we_d   = 1'b1;
                  mem_addr_d = row_base(cmd_in.y) + fb_addr_t'(cmd_in.x);
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_WRITE: begin
`ifdef FB_FILL_EN
            if (col_q == ew_q - 1'b1) begin
               if (row_q == eh_q - 1'b1) begin
                  state_d = ST_DONE;
               end else begin
                  col_d       = '0;
                  row_d       = row_q + 1'b1;
                  row_start_d = row_start_q + fb_addr_t'(SCREEN_X);
                  mem_we_d    = 1'b1;
                  mem_addr_d  = row_start_d;
               end
            end else begin
               col_d      = col_q + 1'b1;
               mem_we_d   = 1'b1;
               mem_addr_d = mem_addr_q + 1'b1;
            end
`else
            state_d = ST_DONE;
`endif
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
`ifdef FB_FILL_EN
         col_q       <= '0;
         row_q       <= '0;
         ew_q        <= '0;
         eh_q        <= '0;
         row_start_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
`ifdef FB_FILL_EN
         col_q       <= col_d;
         row_q       <= row_d;
         ew_q        <= ew_d;
         eh_q        <= eh_d;
         row_start_q <= row_start_d;
`endif
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_data  = mem_data_q;
   assign dbg_state = state_q;

endmodule
